// File: rtl/rx_pkg.sv
// Constants and state encoding shared along the receive chain
// (transmitter, rx_frontend, demodulator).
package rx_pkg;
  localparam int SAMPLE_W          = 18;
  localparam int PAD_W             = 3;
  localparam int ATTEN_W           = 5;
  localparam int ATTEN_REF_DEFAULT = 16;
  localparam int GAIN_W            = 3;

  typedef enum logic [1:0] {CAL, SOLVE, RUN} rx_state_e;

  // Unsigned left shift clamped to full scale.
  function automatic logic [SAMPLE_W-1:0] sat_shl(input logic [SAMPLE_W-1:0] x,
                                                  input logic [GAIN_W-1:0]   sh);
    logic [SAMPLE_W+6:0] w;
    w = {7'd0, x} << sh;
    return (|w[SAMPLE_W+6:SAMPLE_W]) ? {SAMPLE_W{1'b1}} : w[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/rx_sample_fifo.sv
// Small register-based FIFO; head is read combinationally from storage.
// Full/empty use one extra pointer bit beyond the address.
module rx_sample_fifo
  import rx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = SAMPLE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                        do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule

// File: rtl/rx_frontend.sv
// Receive front end: pilot-averaged power-of-two gain calibration, pad strip,
// saturating gain, and a valid/ready sample FIFO toward the demodulator.
module rx_frontend
  import rx_pkg::*;
#(
  parameter int ATTEN_REF = ATTEN_REF_DEFAULT,
  parameter int CAL_LOG2  = 4,
  parameter int MAX_SHIFT = 7,
  parameter int DEPTH     = 4
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [20:0] SIGNAL_IN,
  input  logic        IN_VALID,
  input  logic [4:0]  ATTEN_IN,
  input  logic        START_CAL,
  input  logic        OUT_READY,
  output logic [17:0] OUT_DATA,
  output logic        OUT_VALID,
  output logic [2:0]  GAIN_SHIFT,
  output logic        CAL_DONE,
  output logic        LOS,
  output logic        OVERFLOW,
  output logic [7:0]  PAD_ERR_CNT
);
  localparam int SUM_W = ATTEN_W + CAL_LOG2;
  localparam int CMP_W = SUM_W + MAX_SHIFT;

  rx_state_e               state_q, state_d;
  logic [SUM_W-1:0]        sum_q, sum_d, avg_q, avg_d, sum_nxt;
  logic [CAL_LOG2-1:0]     cnt_q, cnt_d;
  logic [GAIN_W-1:0]       shift_q, shift_d, gain_q, gain_d;
  logic                    los_q, los_d;
  logic                    stg_vld_q, stg_vld_d;
  logic [SAMPLE_W-1:0]     stg_data_q, stg_data_d;
  logic                    ovf_q, ovf_d;
  logic [7:0]              pad_q, pad_d;
  logic [CMP_W-1:0]        scaled;
  logic                    fifo_empty, fifo_full, fifo_drop, pop;

  assign sum_nxt = sum_q + SUM_W'(ATTEN_IN);
  // Wide enough that avg << MAX_SHIFT never truncates.
  assign scaled  = CMP_W'(avg_q) << shift_q;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    avg_d   = avg_q;
    shift_d = shift_q;
    gain_d  = gain_q;
    los_d   = los_q;
    if (START_CAL) begin
      state_d = CAL;
      sum_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        CAL: if (IN_VALID) begin
          sum_d = sum_nxt;
          cnt_d = cnt_q + CAL_LOG2'(1);
          if (cnt_q == {CAL_LOG2{1'b1}}) begin
            avg_d   = sum_nxt >> CAL_LOG2;
            sum_d   = '0;
            shift_d = '0;
            state_d = SOLVE;
          end
        end
        SOLVE: begin
          if (scaled < CMP_W'(ATTEN_REF) && shift_q < GAIN_W'(MAX_SHIFT)) begin
            shift_d = shift_q + GAIN_W'(1);
          end else begin
            gain_d  = shift_q;
            los_d   = (avg_q == '0);
            state_d = RUN;
          end
        end
        RUN:     ;
        default: state_d = CAL;
      endcase
    end
  end

  // Capture only in RUN; an already captured entry drains regardless of state.
  always_comb begin
    stg_vld_d  = (state_q == RUN) && IN_VALID;
    stg_data_d = stg_vld_d ? sat_shl(SIGNAL_IN[PAD_W +: SAMPLE_W], gain_q) : stg_data_q;
    pad_d      = pad_q;
    if (IN_VALID && (SIGNAL_IN[PAD_W-1:0] != '0) && (pad_q != 8'hFF))
      pad_d = pad_q + 8'd1;
    ovf_d      = ovf_q | fifo_drop;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= CAL;
      sum_q      <= '0;
      cnt_q      <= '0;
      avg_q      <= '0;
      shift_q    <= '0;
      gain_q     <= '0;
      los_q      <= 1'b0;
      stg_vld_q  <= 1'b0;
      stg_data_q <= '0;
      ovf_q      <= 1'b0;
      pad_q      <= '0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      avg_q      <= avg_d;
      shift_q    <= shift_d;
      gain_q     <= gain_d;
      los_q      <= los_d;
      stg_vld_q  <= stg_vld_d;
      stg_data_q <= stg_data_d;
      ovf_q      <= ovf_d;
      pad_q      <= pad_d;
    end
  end

  assign pop = OUT_VALID && OUT_READY;

  rx_sample_fifo #(.DEPTH(DEPTH), .WIDTH(SAMPLE_W)) u_fifo (
    .clk     (CLOCK_50),
    .rst_n   (RESET_N),
    .push    (stg_vld_q),
    .wr_data (stg_data_q),
    .pop     (pop),
    .rd_data (OUT_DATA),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .drop    (fifo_drop)
  );

  assign OUT_VALID   = !fifo_empty;
  assign GAIN_SHIFT  = gain_q;
  assign CAL_DONE    = (state_q == RUN);
  assign LOS         = los_q;
  assign OVERFLOW    = ovf_q;
  assign PAD_ERR_CNT = pad_q;
endmodule

// File: doc/rx_frontend.md
Name: rx_frontend

Overview:
- Receive-side stage directly downstream of the transmitter; consumes its 21-bit padded sample stream and its 5-bit attenuation pilot after they cross the channel.
- Calibrates a power-of-two gain from the averaged pilot against the known launch value (16).
- Strips the 3 pad bits, applies the gain with saturation, and buffers samples into a small FIFO with a valid/ready interface for the demodulator.

Parameters:
- ATTEN_REF, 16, known pilot launch value; must match the transmitter constant.
- CAL_LOG2, 4, log2 of the number of pilot samples averaged (16 samples).
- MAX_SHIFT, 7, maximum gain shift; GAIN_SHIFT width is 3.
- DEPTH, 4, output FIFO depth; must be a power of two.

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- SIGNAL_IN  in  21  channel sample: [20:3] payload, [2:0] pad (expected 0).
- IN_VALID  in  1  SIGNAL_IN and ATTEN_IN are valid this cycle.
- ATTEN_IN  in  5  received attenuation pilot.
- START_CAL  in  1  single-cycle recalibration request.
- OUT_READY  in  1  downstream accepts OUT_DATA.
- OUT_DATA  out  18  gain-corrected sample (FIFO head).
- OUT_VALID  out  1  FIFO not empty.
- GAIN_SHIFT  out  3  current gain shift.
- CAL_DONE  out  1  high while in RUN.
- LOS  out  1  loss of signal: calibrated average was 0.
- OVERFLOW  out  1  sticky; a sample was dropped because the FIFO was full.
- PAD_ERR_CNT  out  8  saturating count of samples with nonzero pad bits.

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - State = CAL; accumulator and sample count = 0; FIFO empty; stage register invalid.
  - All outputs 0, including OUT_DATA, OUT_VALID, GAIN_SHIFT, CAL_DONE, LOS, OVERFLOW and PAD_ERR_CNT.
- States CAL, SOLVE, RUN:
  - CAL: on each IN_VALID, sum += ATTEN_IN (width 5+CAL_LOG2) and count++. After 2^CAL_LOG2 valid samples: avg = sum >> CAL_LOG2, s = 0, go to SOLVE.
  - SOLVE: each cycle, if (avg << s) < ATTEN_REF and s < MAX_SHIFT then s++; otherwise latch GAIN_SHIFT = s, set LOS = (avg == 0), go to RUN. Compare at width 5+MAX_SHIFT with no truncation. Takes at most MAX_SHIFT+1 cycles.
  - RUN: CAL_DONE = 1; the datapath is active.
  - START_CAL in any state: clear sum, count and CAL_DONE, then enter CAL. GAIN_SHIFT and LOS hold their old values until the next SOLVE exit. In CAL this restarts accumulation.
- Datapath, RUN only:
  - On IN_VALID, the stage register captures min((SIGNAL_IN[20:3] << GAIN_SHIFT), 18'h3FFFF), with the payload treated as unsigned.
  - Next cycle the stage register pushes into the FIFO.
  - Latency: IN_VALID at edge k means the sample is in the stage register after edge k, and OUT_VALID=1 after edge k+1 when the FIFO was empty.
  - Samples arriving in CAL or SOLVE are not pushed. A stage entry already captured still drains into the FIFO.
- Pad check: in any state, IN_VALID with SIGNAL_IN[2:0] != 0 increments PAD_ERR_CNT, saturating at 255. The sample is still processed normally.
- FIFO:
  - Pop when OUT_VALID && OUT_READY. OUT_DATA shows the head and holds stable while OUT_READY=0.
  - A push is accepted if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Push on full with no pop: sample dropped, OVERFLOW set (cleared only by reset), contents unchanged.
  - Push and pop on empty: the new sample appears at the head next cycle.
  - Pointers wrap modulo DEPTH; full/empty are tracked with an extra pointer bit.
- Reset mid-operation: immediate clear per the reset rule; any FIFO contents are lost.

Decomposition:
- Shared package rx_pkg:
  - Constants SAMPLE_W=18, PAD_W=3, ATTEN_W=5, ATTEN_REF_DEFAULT=16.
  - State enum {CAL, SOLVE, RUN}.
  - These constants are shared with the transmitter and the demodulator.
- Sub-module rx_sample_fifo (parameter DEPTH, WIDTH): push/pop/full/empty, registered storage, no output register.

Test Plan:
- ATTEN_IN=16 for 16 valid samples -> SOLVE exits with GAIN_SHIFT=0, LOS=0, CAL_DONE=1. SIGNAL_IN=21'h000808 -> OUT_DATA=18'h00101, 2 cycles after IN_VALID.
- ATTEN_IN=4 during CAL -> GAIN_SHIFT=2. Payload 18'h00100 -> OUT_DATA=18'h00400. Payload 18'h20000 -> OUT_DATA=18'h3FFFF (saturated).
- ATTEN_IN=0 during CAL -> GAIN_SHIFT=7, LOS=1, SOLVE lasts 8 cycles.
- OUT_READY=0 in RUN, 6 consecutive valid samples -> 4 in FIFO, OVERFLOW=1. Then OUT_READY=1 -> the first 4 samples emerge in order, then OUT_VALID=0.
- 3 samples with pad 3'b101 plus 2 with pad 0 -> PAD_ERR_CNT=3, all 5 samples delivered. 300 bad-pad samples -> PAD_ERR_CNT=255.
- START_CAL mid-RUN with samples queued -> CAL_DONE=0, queued samples still drain, new inputs not pushed until recalibration. RESET_N low mid-RUN -> all outputs 0 at once, state CAL.
